// File: rtl/conv_pkg.sv
// Shared types and helpers for the row convolution engine.
// Accumulator sizing holds 9 worst-case signed 8b x unsigned 8b products without overflow.
package conv_pkg;

  localparam int ACC_W  = 21;
  localparam int PROD_W = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    FINISH  = 2'd3
  } conv_state_e;

  function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] v);
    if (v < $signed(ACC_W'(0))) begin
      return 8'd0;
    end else if (v > $signed(ACC_W'(255))) begin
      return 8'hff;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/conv_row_engine_if.sv
// Control, window-buffer and output-BRAM signals of the row convolution engine.
// master = controller/loader side, slave = engine.
interface conv_row_engine_if #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int FILTER_SIZE  = 3
);
  localparam int OUT_W  = IMAGE_WIDTH - FILTER_SIZE + 1;
  localparam int OUT_H  = IMAGE_HEIGHT - FILTER_SIZE + 1;
  localparam int ADDR_W = $clog2(OUT_H * OUT_W);

  logic                                 start;
  logic [15:0]                          row_count;
  logic [FILTER_SIZE*IMAGE_WIDTH*8-1:0] row_buffer_flat;
  logic [FILTER_SIZE*FILTER_SIZE*8-1:0] kernel_flat;
  logic [3:0]                           shift;
  logic                                 out_bram_en;
  logic                                 out_bram_we;
  logic [ADDR_W-1:0]                    out_bram_addr;
  logic [7:0]                           out_bram_data;
  logic                                 busy;
  logic                                 done;

  modport master (
    output start, row_count, row_buffer_flat, kernel_flat, shift,
    input  out_bram_en, out_bram_we, out_bram_addr, out_bram_data, busy, done
  );

  modport slave (
    input  start, row_count, row_buffer_flat, kernel_flat, shift,
    output out_bram_en, out_bram_we, out_bram_addr, out_bram_data, busy, done
  );

endinterface

// File: rtl/conv_window_mac.sv
// Combinational 3x3 signed-kernel x unsigned-pixel dot product over window columns col..col+2.
// Zero latency; the caller registers the sum.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = 128,
  parameter int FILTER_SIZE = 3,
  parameter int COL_W       = 7
) (
  input  logic [FILTER_SIZE*IMAGE_WIDTH*8-1:0] row_buffer_flat,
  input  logic [FILTER_SIZE*FILTER_SIZE*8-1:0] kernel_flat,
  input  logic [COL_W-1:0]                     col,
  output logic signed [ACC_W-1:0]              sum
);

  localparam int IDX_W = $clog2(FILTER_SIZE * IMAGE_WIDTH * 8);

  logic signed [7:0]        coef;
  logic [7:0]               pix;
  logic signed [PROD_W-1:0] prod;
  logic [IDX_W-1:0]         idx;

  always_comb begin
    sum  = '0;
    coef = '0;
    pix  = '0;
    prod = '0;
    idx  = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        coef = kernel_flat[(i*FILTER_SIZE+j)*8 +: 8];
        idx  = IDX_W'((i*IMAGE_WIDTH + j) * 8) + (IDX_W'(col) << 3);
        pix  = row_buffer_flat[idx +: 8];
        // Zero-extend the pixel so the multiply stays signed.
        prod = coef * $signed({1'b0, pix});
        sum  = sum + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
    end
  end

endmodule

// File: rtl/conv_row_engine.sv
// Slides a 3x3 signed kernel across one buffered row window, writing one clamped pixel per cycle.
// Two-stage pipeline (MAC -> scale/clamp); first write two cycles after accept, start ignored while busy.
module conv_row_engine
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int FILTER_SIZE  = 3
) (
  input logic              clk,
  input logic              rst,
  conv_row_engine_if.slave bus
);

  localparam int OUT_W  = IMAGE_WIDTH - FILTER_SIZE + 1;
  localparam int OUT_H  = IMAGE_HEIGHT - FILTER_SIZE + 1;
  localparam int ADDR_W = $clog2(OUT_H * OUT_W);
  localparam int COL_W  = $clog2(OUT_W);
  localparam int KER_W  = FILTER_SIZE * FILTER_SIZE * 8;

  conv_state_e state_q, state_d;

  logic [COL_W-1:0]        col_q, col_d;
  logic [KER_W-1:0]        kernel_q, kernel_d;
  logic [3:0]              shift_q, shift_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic                    row_ok_q, row_ok_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    s1_vld_q, s1_vld_d;
  logic signed [ACC_W-1:0] s1_acc_q, s1_acc_d;
  logic [ADDR_W-1:0]       s1_addr_q, s1_addr_d;

  logic                    wr_en_q, wr_en_d;
  logic                    wr_we_q, wr_we_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;

  logic signed [ACC_W-1:0] mac_sum;
  logic                    col_last;

  assign col_last = (col_q == COL_W'(OUT_W - 1));

  conv_window_mac #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .FILTER_SIZE (FILTER_SIZE),
    .COL_W       (COL_W)
  ) u_mac (
    .row_buffer_flat (bus.row_buffer_flat),
    .kernel_flat     (kernel_q),
    .col             (col_q),
    .sum             (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = COMPUTE;
      COMPUTE: if (col_last) state_d = DRAIN;
      DRAIN:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d     = col_q;
    kernel_d  = kernel_q;
    shift_d   = shift_q;
    base_d    = base_q;
    row_ok_d  = row_ok_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    s1_vld_d  = (state_q == COMPUTE);
    s1_acc_d  = mac_sum;
    s1_addr_d = base_q + ADDR_W'(col_q);

    // Rows past the output image run the full timeline but never write.
    wr_en_d   = s1_vld_q & row_ok_q;
    wr_we_d   = s1_vld_q & row_ok_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (s1_vld_q && row_ok_q) begin
      wr_addr_d = s1_addr_q;
      wr_data_d = clamp8(s1_acc_q >>> shift_q);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          col_d    = '0;
          kernel_d = bus.kernel_flat;
          shift_d  = bus.shift;
          base_d   = ADDR_W'(32'(bus.row_count) * 32'(OUT_W));
          row_ok_d = (bus.row_count < 16'(OUT_H));
          busy_d   = 1'b1;
        end
      end
      COMPUTE: begin
        if (!col_last) col_d = col_q + COL_W'(1);
      end
      FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      kernel_q  <= '0;
      shift_q   <= '0;
      base_q    <= '0;
      row_ok_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_acc_q  <= '0;
      s1_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_we_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      col_q     <= col_d;
      kernel_q  <= kernel_d;
      shift_q   <= shift_d;
      base_q    <= base_d;
      row_ok_q  <= row_ok_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s1_vld_q  <= s1_vld_d;
      s1_acc_q  <= s1_acc_d;
      s1_addr_q <= s1_addr_d;
      wr_en_q   <= wr_en_d;
      wr_we_q   <= wr_we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.out_bram_en   = wr_en_q;
  assign bus.out_bram_we   = wr_we_q;
  assign bus.out_bram_addr = wr_addr_q;
  assign bus.out_bram_data = wr_data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_conv_row_engine.sv
// Directed bench for conv_row_engine: write stream, timing, clamping, restart and reset behaviour.
module tb_conv_row_engine;

  localparam int W     = 128;
  localparam int OUT_W = 126;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int wr_flags[$];
  int done_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  conv_row_engine_if bus ();

  conv_row_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Write/done logger; sampled mid-cycle so cyc is the index of the last rising edge.
  always @(negedge clk) begin
    if (bus.out_bram_en || bus.out_bram_we) begin
      wr_addr.push_back(int'(bus.out_bram_addr));
      wr_data.push_back(int'(bus.out_bram_data));
      wr_cyc.push_back(cyc);
      wr_flags.push_back({30'd0, bus.out_bram_en, bus.out_bram_we});
    end
    if (bus.done) done_cyc.push_back(cyc);
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    wr_flags.delete();
    done_cyc.delete();
  endtask

  // Called at a falling edge; k is the rising edge that accepts the request.
  task automatic start_row(input int r, output int k);
    bus.row_count = 16'(r);
    bus.start     = 1'b1;
    k             = cyc + 1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < W; j++)
        bus.row_buffer_flat[(i*W+j)*8 +: 8] = 8'(v);
  endtask

  // row0 = 200, row1 = j, row2 = 255-j
  task automatic fill_ramp();
    for (int j = 0; j < W; j++) begin
      bus.row_buffer_flat[(0*W+j)*8 +: 8] = 8'(200);
      bus.row_buffer_flat[(1*W+j)*8 +: 8] = 8'(j);
      bus.row_buffer_flat[(2*W+j)*8 +: 8] = 8'(255 - j);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.row_count = '0;
    bus.shift = '0;
    bus.kernel_flat = '0;
    bus.row_buffer_flat = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.out_bram_en !== 1'b0)  begin bad++; $display("FAIL reset_en: got %b want 0", bus.out_bram_en); end
    total++; if (bus.out_bram_we !== 1'b0)  begin bad++; $display("FAIL reset_we: got %b want 0", bus.out_bram_we); end
    total++; if (bus.out_bram_addr !== '0)  begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.out_bram_addr); end
    total++; if (bus.out_bram_data !== '0)  begin bad++; $display("FAIL reset_data: got %0d want 0", bus.out_bram_data); end
    total++; if (bus.busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0)         begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int k, n;
    fill_ramp();
    bus.kernel_flat = '0;
    bus.kernel_flat[4*8 +: 8] = 8'd1;
    bus.shift = 4'd0;
    clear_log();
    start_row(5, k);
    wait_until(k + 135);
    n = wr_addr.size();
    total++; if (n !== OUT_W) begin bad++; $display("FAIL identity_count: got %0d want %0d", n, OUT_W); end
    for (int i = 0; i < n && i < OUT_W; i++) begin
      total++;
      if (wr_addr[i] !== 630 + i || wr_data[i] !== i + 1 || wr_cyc[i] !== k + 2 + i || wr_flags[i] !== 3) begin
        bad++;
        $display("FAIL identity_wr[%0d]: addr=%0d data=%0d edge=%0d enwe=%0d want addr=%0d data=%0d edge=%0d enwe=3",
                 i, wr_addr[i], wr_data[i], wr_cyc[i], wr_flags[i], 630 + i, i + 1, k + 2 + i);
      end
    end
    total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== k + 128) begin
      bad++; $display("FAIL identity_done: count=%0d first=%0d want count=1 at %0d", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, k + 128);
    end

    // Bottom-left tap with a shift: data = (255-c) >> 1
    bus.kernel_flat = '0;
    bus.kernel_flat[6*8 +: 8] = 8'd1;
    bus.shift = 4'd1;
    clear_log();
    start_row(3, k);
    wait_until(k + 135);
    n = wr_addr.size();
    total++; if (n !== OUT_W) begin bad++; $display("FAIL offset_count: got %0d want %0d", n, OUT_W); end
    for (int i = 0; i < n && i < OUT_W; i++) begin
      total++;
      if (wr_addr[i] !== 378 + i || wr_data[i] !== (255 - i) / 2) begin
        bad++;
        $display("FAIL offset_wr[%0d]: addr=%0d data=%0d want addr=%0d data=%0d", i, wr_addr[i], wr_data[i], 378 + i, (255 - i) / 2);
      end
    end
  endtask

  task automatic test_clamp_high();
    int k, n;
    fill_const(255);
    for (int i = 0; i < 9; i++) bus.kernel_flat[i*8 +: 8] = 8'd1;
    bus.shift = 4'd3;
    clear_log();
    start_row(125, k);
    wait_until(k + 135);
    n = wr_addr.size();
    total++; if (n !== OUT_W) begin bad++; $display("FAIL clamp_high_count: got %0d want %0d", n, OUT_W); end
    for (int i = 0; i < n && i < OUT_W; i++) begin
      total++;
      if (wr_addr[i] !== 15750 + i || wr_data[i] !== 255) begin
        bad++; $display("FAIL clamp_high_wr[%0d]: addr=%0d data=%0d want addr=%0d data=255", i, wr_addr[i], wr_data[i], 15750 + i);
      end
    end
  endtask

  task automatic test_clamp_low();
    int k, n;
    // centre -1 over pixels of 10 -> -10 -> 0
    fill_const(10);
    bus.kernel_flat = '0;
    bus.kernel_flat[4*8 +: 8] = 8'hff;
    bus.shift = 4'd0;
    clear_log();
    start_row(0, k);
    wait_until(k + 135);
    n = wr_addr.size();
    total++; if (n !== OUT_W) begin bad++; $display("FAIL clamp_low_count: got %0d want %0d", n, OUT_W); end
    for (int i = 0; i < n && i < OUT_W; i++) begin
      total++;
      if (wr_addr[i] !== i || wr_data[i] !== 0) begin
        bad++; $display("FAIL clamp_low_wr[%0d]: addr=%0d data=%0d want addr=%0d data=0", i, wr_addr[i], wr_data[i], i);
      end
    end

    // centre -128 with pixel 255 -> -32640 -> 0
    fill_const(255);
    bus.kernel_flat[4*8 +: 8] = 8'h80;
    clear_log();
    start_row(1, k);
    wait_until(k + 135);
    n = wr_addr.size();
    total++; if (n !== OUT_W) begin bad++; $display("FAIL minprod_count: got %0d want %0d", n, OUT_W); end
    for (int i = 0; i < n && i < OUT_W; i++) begin
      total++;
      if (wr_data[i] !== 0) begin bad++; $display("FAIL minprod_wr[%0d]: data=%0d want 0", i, wr_data[i]); end
    end

    // 127*255*2 - 128*255 = 32130; >>>7 = 251
    bus.kernel_flat[0*8 +: 8] = 8'd127;
    bus.kernel_flat[1*8 +: 8] = 8'd127;
    bus.shift = 4'd7;
    clear_log();
    start_row(2, k);
    wait_until(k + 135);
    n = wr_addr.size();
    total++; if (n !== OUT_W) begin bad++; $display("FAIL mixprod_count: got %0d want %0d", n, OUT_W); end
    for (int i = 0; i < n && i < OUT_W; i++) begin
      total++;
      if (wr_addr[i] !== 252 + i || wr_data[i] !== 251) begin
        bad++; $display("FAIL mixprod_wr[%0d]: addr=%0d data=%0d want addr=%0d data=251", i, wr_addr[i], wr_data[i], 252 + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, k2, n;
    fill_ramp();
    bus.kernel_flat = '0;
    bus.kernel_flat[4*8 +: 8] = 8'd1;
    bus.shift = 4'd0;
    clear_log();
    start_row(7, k);
    // Stray requests at accept edges k+5 and k+60 with a different row.
    wait_until(k + 4);
    bus.row_count = 16'd20; bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    wait_until(k + 59);
    bus.row_count = 16'd20; bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    // Earliest legal re-accept at edge k+129.
    wait_until(k + 128);
    start_row(8, k2);
    total++; if (k2 !== k + 129) begin bad++; $display("FAIL b2b_accept_edge: got %0d want %0d", k2, k + 129); end
    wait_until(k2 + 135);
    n = wr_addr.size();
    total++; if (n !== 2 * OUT_W) begin bad++; $display("FAIL b2b_count: got %0d want %0d", n, 2 * OUT_W); end
    for (int i = 0; i < n && i < 2 * OUT_W; i++) begin
      int c, ea, ec;
      c  = i % OUT_W;
      ea = (i < OUT_W) ? 882 + c : 1008 + c;
      ec = (i < OUT_W) ? k + 2 + c : k2 + 2 + c;
      total++;
      if (wr_addr[i] !== ea || wr_data[i] !== c + 1 || wr_cyc[i] !== ec) begin
        bad++;
        $display("FAIL b2b_wr[%0d]: addr=%0d data=%0d edge=%0d want addr=%0d data=%0d edge=%0d", i, wr_addr[i], wr_data[i], wr_cyc[i], ea, c + 1, ec);
      end
    end
    total++;
    if (done_cyc.size() !== 2 || done_cyc[0] !== k + 128 || done_cyc[1] !== k2 + 128) begin
      bad++; $display("FAIL b2b_done: count=%0d want 2 at %0d and %0d", done_cyc.size(), k + 128, k2 + 128);
    end
  endtask

  task automatic test_reset_mid();
    int k, k2, n, late;
    fill_ramp();
    bus.kernel_flat = '0;
    bus.kernel_flat[4*8 +: 8] = 8'd1;
    bus.shift = 4'd0;
    clear_log();
    start_row(9, k);
    wait_until(k + 49);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.out_bram_en !== 1'b0) begin bad++; $display("FAIL midrst_en: got %b want 0", bus.out_bram_en); end
    total++; if (bus.out_bram_we !== 1'b0) begin bad++; $display("FAIL midrst_we: got %b want 0", bus.out_bram_we); end
    total++; if (bus.busy !== 1'b0)        begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    wait_until(k + 54);
    late = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] >= k + 50) late++;
    total++; if (late !== 0) begin bad++; $display("FAIL midrst_late_writes: got %0d want 0", late); end
    total++; if (done_cyc.size() !== 0) begin bad++; $display("FAIL midrst_done: got %0d pulses want 0", done_cyc.size()); end
    total++; if (wr_addr.size() !== 48) begin bad++; $display("FAIL midrst_pre_writes: got %0d want 48", wr_addr.size()); end

    clear_log();
    start_row(9, k2);
    wait_until(k2 + 135);
    n = wr_addr.size();
    total++; if (n !== OUT_W) begin bad++; $display("FAIL midrst_restart_count: got %0d want %0d", n, OUT_W); end
    for (int i = 0; i < n && i < OUT_W; i++) begin
      total++;
      if (wr_addr[i] !== 1134 + i || wr_data[i] !== i + 1 || wr_cyc[i] !== k2 + 2 + i) begin
        bad++;
        $display("FAIL midrst_restart_wr[%0d]: addr=%0d data=%0d edge=%0d want addr=%0d data=%0d edge=%0d",
                 i, wr_addr[i], wr_data[i], wr_cyc[i], 1134 + i, i + 1, k2 + 2 + i);
      end
    end
    total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== k2 + 128) begin
      bad++; $display("FAIL midrst_restart_done: count=%0d want 1 at %0d", done_cyc.size(), k2 + 128);
    end
  endtask

  task automatic test_out_of_range();
    int k;
    fill_ramp();
    clear_log();
    start_row(126, k);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL oor_busy_start: got %b want 1", bus.busy); end
    wait_until(k + 127);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL oor_busy_last: got %b want 1", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL oor_done_early: got %b want 0", bus.done); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL oor_busy_end: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL oor_done: got %b want 1", bus.done); end
    wait_until(k + 135);
    total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL oor_writes: got %0d want 0", wr_addr.size()); end
    total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== k + 128) begin
      bad++; $display("FAIL oor_done_count: count=%0d want 1 at %0d", done_cyc.size(), k + 128);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_clamp_high();
    test_clamp_low();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
